// File: rtl/ex_muldiv_unit.sv
// ex_muldiv_unit: iterative MULT/MULTU/DIV/DIVU unit for the EX stage.
// It owns the HI/LO registers. Each operation takes 34 cycles: one start
// cycle, 32 radix-2 steps and one sign-fix cycle. The unit stalls the
// pipeline front when a HI/LO user arrives while an operation is in flight.
module ex_muldiv_unit (
  input  logic        Clk,
  input  logic        Rst,
  input  logic        start,
  input  logic [1:0]  op,
  input  logic [31:0] operand_a,
  input  logic [31:0] operand_b,
  input  logic        mt_hi,
  input  logic        mt_lo,
  input  logic        mf_req,
  output logic        stall_out,
  output logic        done,
  output logic        div_by_zero,
  output logic [31:0] HI,
  output logic [31:0] LO
);

  typedef enum logic [1:0] {IDLE, BUSY, FIX} state_t;

  localparam logic [1:0] OP_MULT = 2'b00;
  localparam logic [1:0] OP_DIV  = 2'b10;

  state_t      state;
  logic [5:0]  cnt;
  // Multiply: acc = {partial product high, multiplier shifting out}.
  // Divide:   acc = {remainder, dividend shifting out / quotient shifting in}.
  logic [63:0] acc;
  // The operand not held in acc: multiplicand magnitude or divisor magnitude.
  logic [31:0] opnd;
  logic        is_div;
  logic        a_neg;
  logic        b_neg;

  // Start-time decode of signedness and operand magnitudes.
  logic        start_signed;
  logic        start_a_neg;
  logic        start_b_neg;
  logic [31:0] start_a_mag;
  logic [31:0] start_b_mag;

  assign start_signed = (op == OP_MULT) || (op == OP_DIV);
  assign start_a_neg  = start_signed && operand_a[31];
  assign start_b_neg  = start_signed && operand_b[31];
  assign start_a_mag  = start_a_neg ? (32'd0 - operand_a) : operand_a;
  assign start_b_mag  = start_b_neg ? (32'd0 - operand_b) : operand_b;

  // Combinational stall: only while an operation is in flight; never in reset.
  assign stall_out = !Rst && (state != IDLE) && (start || mf_req || mt_hi || mt_lo);

  // One radix-2 step of either shift-add multiply or restoring divide.
  logic [32:0] mul_sum;
  logic [32:0] div_trial;
  logic [32:0] div_diff;
  logic [63:0] acc_step;

  always_comb begin
    // NOTE: every signal gets a default first so no path leaves it unassigned,
    // which would otherwise infer a latch.
    acc_step  = acc;
    mul_sum   = '0;
    div_trial = '0;
    div_diff  = '0;
    if (is_div) begin
      div_trial = {acc[63:32], acc[31]};
      div_diff  = div_trial - {1'b0, opnd};
      if (!div_diff[32]) acc_step = {div_diff[31:0], acc[30:0], 1'b1};
      else               acc_step = {div_trial[31:0], acc[30:0], 1'b0};
    end else begin
      mul_sum  = {1'b0, acc[63:32]} + (acc[0] ? {1'b0, opnd} : 33'd0);
      acc_step = {mul_sum, acc[31:1]};
    end
  end

  // Sign correction applied in FIX.
  logic        res_neg;
  logic [63:0] prod_fixed;
  logic [31:0] quo_fixed;
  logic [31:0] rem_fixed;

  assign res_neg    = a_neg ^ b_neg;
  assign prod_fixed = res_neg ? (64'd0 - acc) : acc;
  assign quo_fixed  = (opnd == 32'd0) ? 32'hFFFF_FFFF
                    : (res_neg ? (32'd0 - acc[31:0]) : acc[31:0]);
  // With a zero divisor the remainder ends up as |a|; restoring the dividend
  // sign yields operand_a exactly.
  assign rem_fixed  = a_neg ? (32'd0 - acc[63:32]) : acc[63:32];

  // Sequencer, datapath registers and architectural HI/LO.
  always_ff @(posedge Clk) begin
    if (Rst) begin
      // NOTE: sequential state uses non-blocking assignments only, so every
      // register samples pre-edge values regardless of statement order.
      state       <= IDLE;
      cnt         <= '0;
      acc         <= '0;
      opnd        <= '0;
      is_div      <= 1'b0;
      a_neg       <= 1'b0;
      b_neg       <= 1'b0;
      HI          <= '0;
      LO          <= '0;
      done        <= 1'b0;
      div_by_zero <= 1'b0;
    end else begin
      done        <= 1'b0;
      div_by_zero <= 1'b0;
      unique case (state)
        IDLE: begin
          if (start) begin
            is_div <= op[1];
            a_neg  <= start_a_neg;
            b_neg  <= start_b_neg;
            cnt    <= '0;
            if (op[1]) begin
              acc  <= {32'd0, start_a_mag};
              opnd <= start_b_mag;
            end else begin
              acc  <= {32'd0, start_b_mag};
              opnd <= start_a_mag;
            end
            state <= BUSY;
          end else begin
            if (mt_hi) HI <= operand_a;
            if (mt_lo) LO <= operand_a;
          end
        end
        BUSY: begin
          acc <= acc_step;
          cnt <= cnt + 6'd1;
          if (cnt == 6'd31) state <= FIX;
        end
        FIX: begin
          if (is_div) begin
            HI          <= rem_fixed;
            LO          <= quo_fixed;
            div_by_zero <= (opnd == 32'd0);
          end else begin
            HI <= prod_fixed[63:32];
            LO <= prod_fixed[31:0];
          end
          done  <= 1'b1;
          state <= IDLE;
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule
